// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP-style controller and its datapath.
// Holds the opcode encodings, the control-word bit positions, the
// control-word width and the T-state limits. The datapath decodes
// ctrl with the same CW_* indices, so keep the two in step.
package sap_ctrl_pkg;

    localparam int CW_W     = 16;
    localparam int MAX_STEP = 4;
    localparam int STEP_W   = 3;

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control-word bit indices
    localparam int CW_HLT = 15;
    localparam int CW_MI  = 14;
    localparam int CW_RI  = 13;
    localparam int CW_RO  = 12;
    localparam int CW_IO  = 11;
    localparam int CW_II  = 10;
    localparam int CW_AI  = 9;
    localparam int CW_AO  = 8;
    localparam int CW_EO  = 7;
    localparam int CW_SU  = 6;
    localparam int CW_BI  = 5;
    localparam int CW_OI  = 4;
    localparam int CW_CE  = 3;
    localparam int CW_CO  = 2;
    localparam int CW_J   = 1;
    localparam int CW_FI  = 0;

    // One-hot control word with only bit idx set.
    function automatic logic [CW_W-1:0] cw_bit(input int idx);
        logic [CW_W-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/t_state_counter.sv
// T-state step register.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset, forces step to 0
//   clr   - current step is the instruction's last; next step is 0
//   hold  - keep the current step (start-up cycle or halted)
//   step  - current T-state index, never exceeds MAX_STEP
module t_state_counter
    import sap_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              hold,
    output logic [STEP_W-1:0] step
);

    logic [STEP_W-1:0] step_d;
    logic [STEP_W-1:0] step_q;

    always_comb begin
        step_d = step_q;
        if (hold) begin
            step_d = step_q;
        end else if (clr || (step_q >= STEP_W'(MAX_STEP))) begin
            step_d = '0;
        end else begin
            step_d = step_q + STEP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded controller-sequencer for an 8-bit SAP-style CPU.
// Decodes {instruction, step} into the control word that drives the
// bus, registers, PC, RAM, ALU and output stage.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   instruction - opcode from the instruction register (valid from T2)
//   carry_flag  - registered carry flag, used by JC in T2 only
//   zero_flag   - registered zero flag, used by JZ in T2 only
//   ctrl        - control word (bit map in sap_ctrl_pkg)
//   step        - current T-state index
//   halted      - sticky, set once HLT has executed
module control_sequencer
    import sap_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        instruction,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic [CW_W-1:0]   ctrl,
    output logic [STEP_W-1:0] step,
    output logic              halted
);

    logic [STEP_W-1:0] step_q;
    logic              halted_d, halted_q;
    logic              start_d, start_q;
    logic [CW_W-1:0]   ctrl_raw;
    logic              last_step;
    logic              hlt_t2;
    logic              hold;

    // start_q is low for the first edge after reset release, so T0 is
    // presented for a full cycle even if rst_n rises just before an edge.
    assign hlt_t2 = (step_q == STEP_W'(2)) && (instruction == OP_HLT);
    assign hold   = !start_q || halted_q || hlt_t2;

    t_state_counter u_tsc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (last_step),
        .hold  (hold),
        .step  (step_q)
    );

    // Microcode. Fetch is opcode-independent; undefined opcodes fall to
    // the default, which behaves as NOP (empty T2, then END).
    always_comb begin
        ctrl_raw  = '0;
        last_step = 1'b0;
        casez ({instruction, step_q})
            {4'b????, 3'd0}: ctrl_raw = cw_bit(CW_CO) | cw_bit(CW_MI);
            {4'b????, 3'd1}: ctrl_raw = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
            {OP_LDA, 3'd2}, {OP_ADD, 3'd2}, {OP_SUB, 3'd2}, {OP_STA, 3'd2}:
                ctrl_raw = cw_bit(CW_IO) | cw_bit(CW_MI);
            {OP_LDA, 3'd3}: begin
                ctrl_raw  = cw_bit(CW_RO) | cw_bit(CW_AI);
                last_step = 1'b1;
            end
            {OP_ADD, 3'd3}, {OP_SUB, 3'd3}:
                ctrl_raw = cw_bit(CW_RO) | cw_bit(CW_BI);
            {OP_ADD, 3'd4}: begin
                ctrl_raw  = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI);
                last_step = 1'b1;
            end
            {OP_SUB, 3'd4}: begin
                ctrl_raw  = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI) | cw_bit(CW_SU);
                last_step = 1'b1;
            end
            {OP_STA, 3'd3}: begin
                ctrl_raw  = cw_bit(CW_AO) | cw_bit(CW_RI);
                last_step = 1'b1;
            end
            {OP_LDI, 3'd2}: begin
                ctrl_raw  = cw_bit(CW_IO) | cw_bit(CW_AI);
                last_step = 1'b1;
            end
            {OP_JMP, 3'd2}: begin
                ctrl_raw  = cw_bit(CW_IO) | cw_bit(CW_J);
                last_step = 1'b1;
            end
            {OP_JC, 3'd2}: begin
                ctrl_raw  = carry_flag ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
                last_step = 1'b1;
            end
            {OP_JZ, 3'd2}: begin
                ctrl_raw  = zero_flag ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
                last_step = 1'b1;
            end
            {OP_OUT, 3'd2}: begin
                ctrl_raw  = cw_bit(CW_AO) | cw_bit(CW_OI);
                last_step = 1'b1;
            end
            {OP_HLT, 3'd2}: ctrl_raw = cw_bit(CW_HLT);
            default: begin
                ctrl_raw  = '0;
                last_step = 1'b1;
            end
        endcase
    end

    always_comb begin
        start_d  = 1'b1;
        halted_d = halted_q | hlt_t2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            start_q  <= start_d;
            halted_q <= halted_d;
        end
    end

    assign ctrl   = !rst_n ? '0 : (halted_q ? cw_bit(CW_HLT) : ctrl_raw);
    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  instruction = 4'h0;
    logic        carry_flag = 1'b0;
    logic        zero_flag = 1'b0;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    control_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .ctrl        (ctrl),
        .step        (step),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Expected control words, written directly from the bit map.
    localparam logic [15:0] F0   = 16'h4004;  // co|mi
    localparam logic [15:0] F1   = 16'h1408;  // ro|ii|ce
    localparam logic [15:0] IOMI = 16'h4800;  // io|mi
    localparam logic [15:0] ROAI = 16'h1200;  // ro|ai
    localparam logic [15:0] ROBI = 16'h1020;  // ro|bi
    localparam logic [15:0] ADD4 = 16'h0281;  // eo|ai|fi
    localparam logic [15:0] SUB4 = 16'h02C1;  // eo|ai|fi|su
    localparam logic [15:0] AORI = 16'h2100;  // ao|ri
    localparam logic [15:0] IOAI = 16'h0A00;  // io|ai
    localparam logic [15:0] IOJ  = 16'h0802;  // io|j
    localparam logic [15:0] AOOI = 16'h0110;  // ao|oi
    localparam logic [15:0] HLTW = 16'h8000;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        c;
        logic        z;
        int          len;
        logic [15:0] cw0, cw1, cw2, cw3, cw4;
    } vec_t;

    typedef struct packed {
        logic [2:0]  step;
        logic [15:0] ctrl;
        logic        halted;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add_vec(input string name, input logic [3:0] op, input logic c, input logic z,
                           input int len, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] d, input logic [15:0] e, input logic [15:0] f);
        vec_t v;
        v.name = name; v.op = op; v.c = c; v.z = z; v.len = len;
        v.cw0 = a; v.cw1 = b; v.cw2 = d; v.cw3 = e; v.cw4 = f;
        vecs.push_back(v);
    endtask

    // Pops the oldest expectation and compares it against the DUT now.
    task automatic check_now(input string tag);
        exp_t e;
        int   drivers;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        n_tests++;
        if (step !== e.step || ctrl !== e.ctrl || halted !== e.halted) begin
            n_fail++;
            $display("FAIL %s: got step=%0d ctrl=%h halted=%b, expected step=%0d ctrl=%h halted=%b",
                     tag, step, ctrl, halted, e.step, e.ctrl, e.halted);
        end
        drivers = int'(ctrl[12]) + int'(ctrl[11]) + int'(ctrl[8]) + int'(ctrl[7]) + int'(ctrl[2]);
        n_tests++;
        if (drivers > 1 || step > 3'd4) begin
            n_fail++;
            $display("FAIL %s_bus: got %0d bus drivers step=%0d ctrl=%h, expected <=1 driver step<=4",
                     tag, drivers, step, ctrl);
        end
    endtask

    // Called at posedge+1: queue the expectation, compare at negedge,
    // return at the following posedge+1.
    task automatic cycle(input logic [2:0] es, input logic [15:0] ec, input logic eh, input string tag);
        sb.push_back('{step: es, ctrl: ec, halted: eh});
        @(negedge clk);
        check_now(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] cw;
        for (int t = 0; t < v.len; t++) begin
            instruction = v.op; carry_flag = v.c; zero_flag = v.z;
            case (t)
                0: cw = v.cw0;
                1: cw = v.cw1;
                2: cw = v.cw2;
                3: cw = v.cw3;
                default: cw = v.cw4;
            endcase
            cycle(3'(t), cw, 1'b0, $sformatf("%s_T%0d", v.name, t));
        end
    endtask

    function automatic int ref_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    function automatic logic [15:0] ref_cw(input logic [3:0] op, input int t, input logic c, input logic z);
        if (t == 0) return F0;
        if (t == 1) return F1;
        case (op)
            4'h1: return (t == 2) ? IOMI : ROAI;
            4'h2: return (t == 2) ? IOMI : (t == 3) ? ROBI : ADD4;
            4'h3: return (t == 2) ? IOMI : (t == 3) ? ROBI : SUB4;
            4'h4: return (t == 2) ? IOMI : AORI;
            4'h5: return IOAI;
            4'h6: return IOJ;
            4'h7: return c ? IOJ : 16'h0000;
            4'h8: return z ? IOJ : 16'h0000;
            4'hE: return AOOI;
            4'hF: return HLTW;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        add_vec("nop",   4'h0, 0, 0, 3, F0, F1, 16'h0, 16'h0, 16'h0);
        add_vec("lda",   4'h1, 0, 0, 4, F0, F1, IOMI, ROAI, 16'h0);
        add_vec("add",   4'h2, 0, 0, 5, F0, F1, IOMI, ROBI, ADD4);
        add_vec("sub",   4'h3, 1, 1, 5, F0, F1, IOMI, ROBI, SUB4);
        add_vec("sta",   4'h4, 0, 0, 4, F0, F1, IOMI, AORI, 16'h0);
        add_vec("ldi",   4'h5, 0, 0, 3, F0, F1, IOAI, 16'h0, 16'h0);
        add_vec("jmp",   4'h6, 0, 0, 3, F0, F1, IOJ, 16'h0, 16'h0);
        add_vec("jc_c1", 4'h7, 1, 0, 3, F0, F1, IOJ, 16'h0, 16'h0);
        add_vec("jc_c0", 4'h7, 0, 1, 3, F0, F1, 16'h0, 16'h0, 16'h0);
        add_vec("jz_z1", 4'h8, 0, 1, 3, F0, F1, IOJ, 16'h0, 16'h0);
        add_vec("jz_z0", 4'h8, 1, 0, 3, F0, F1, 16'h0, 16'h0, 16'h0);
        add_vec("out",   4'hE, 0, 0, 3, F0, F1, AOOI, 16'h0, 16'h0);
        for (int u = 9; u <= 13; u++)
            add_vec($sformatf("undef%0d", u), 4'(u), 1, 1, 3, F0, F1, 16'h0, 16'h0, 16'h0);

        // Reset state while rst_n is low.
        #2;
        sb.push_back('{step: 3'd0, ctrl: 16'h0, halted: 1'b0});
        check_now("reset");

        // Release mid-cycle; T0 must still last a full cycle after release.
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset in ADD T3.
        instruction = 4'h2;
        cycle(3'd0, F0, 1'b0, "mid_T0");
        cycle(3'd1, F1, 1'b0, "mid_T1");
        cycle(3'd2, IOMI, 1'b0, "mid_T2");
        sb.push_back('{step: 3'd3, ctrl: ROBI, halted: 1'b0});
        check_now("mid_T3");
        rst_n = 1'b0;
        #1;
        sb.push_back('{step: 3'd0, ctrl: 16'h0, halted: 1'b0});
        check_now("mid_rst");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(vecs[0]);

        // Random opcodes (no HLT); opcode and flags scrambled outside T2.
        for (int k = 0; k < 2400; k++) begin
            logic [3:0] op;
            int         len;
            op  = 4'($urandom_range(0, 14));
            len = ref_len(op);
            for (int t = 0; t < len; t++) begin
                instruction = (t < 2) ? 4'($urandom_range(0, 15)) : op;
                carry_flag  = 1'($urandom);
                zero_flag   = 1'($urandom);
                cycle(3'(t), ref_cw(op, t, carry_flag, zero_flag), 1'b0, $sformatf("rand_op%h_T%0d", op, t));
            end
        end

        // Halt, stay halted, then reset out of it.
        instruction = 4'hF;
        cycle(3'd0, F0, 1'b0, "hlt_T0");
        cycle(3'd1, F1, 1'b0, "hlt_T1");
        cycle(3'd2, HLTW, 1'b0, "hlt_T2");
        for (int k = 0; k < 20; k++) begin
            instruction = 4'($urandom_range(0, 15));
            carry_flag  = 1'($urandom);
            zero_flag   = 1'($urandom);
            cycle(3'd2, HLTW, 1'b1, $sformatf("halted_%0d", k));
        end
        rst_n = 1'b0;
        #1;
        sb.push_back('{step: 3'd0, ctrl: 16'h0, halted: 1'b0});
        check_now("hlt_rst");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
